// File: rtl/dense_ser_pkg.sv
// ----------------------------------------------------------------------------
// dense_ser_pkg
//   Shared types and helpers for the dense-layer output serializer.
//   - ser_state_e : serializer FSM states (IDLE, STREAM)
//   - nchunk()    : number of output chunks per captured vector
//   - cnt_width() : chunk counter width, $clog2 of the chunk count, minimum 1
//   - relu_word() : rectifies one two's-complement word (negative -> 0)
//   - DEF_CNT_W   : counter width for the default geometry (128 words / 4)
// ----------------------------------------------------------------------------
package dense_ser_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } ser_state_e;

    // Widest word relu_word() can handle; narrower words are zero-extended.
    localparam int unsigned MAX_BW       = 32'd64;
    localparam int unsigned DEF_IN_SIZE  = 32'd128;
    localparam int unsigned DEF_OUT_SIZE = 32'd4;
    localparam int unsigned DEF_BW       = 32'd16;

    function automatic int unsigned nchunk(input int unsigned in_size,
                                           input int unsigned out_size);
        return in_size / out_size;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        if (n > 32'd1) begin
            w = $clog2(n);
        end else begin
            w = 32'd1;
        end
        return w;
    endfunction

    localparam int unsigned DEF_CNT_W = cnt_width(nchunk(DEF_IN_SIZE, DEF_OUT_SIZE));

    // word holds a bw-bit value zero-extended to MAX_BW; its sign bit is bit bw-1.
    function automatic logic [MAX_BW-1:0] relu_word(input logic [MAX_BW-1:0] word,
                                                    input int unsigned       bw);
        logic [MAX_BW-1:0] msb_v;
        msb_v = word >> (bw - 32'd1);
        if (msb_v[0]) begin
            return {MAX_BW{1'b0}};
        end else begin
            return word;
        end
    endfunction

endpackage

// File: rtl/vec_pingpong_buf.sv
// ----------------------------------------------------------------------------
// vec_pingpong_buf
//   Two full-vector slots used as a ping-pong buffer. A write stores a whole
//   vector into the write slot and advances the write pointer; freeing the
//   read slot advances the read pointer. Occupancy counts filled slots.
//   The read port selects one chunk of a given slot; when that slot is being
//   written in the same cycle the incoming vector is forwarded so a freshly
//   captured vector can be read before it lands in storage.
// Ports
//   clk, rst       clock, synchronous active-high reset (pointers/occupancy)
//   wr_en          store wr_data into the write slot this cycle
//   wr_data        packed IN_SIZE*BW vector
//   rd_free        release the current read slot (last chunk issued)
//   rd_slot_sel    slot addressed by the read port
//   rd_chunk_sel   chunk index addressed by the read port
//   rd_data        selected OUT_SIZE*BW chunk (combinational)
//   rd_slot        current read pointer
//   occ            number of filled slots (0..2)
// ----------------------------------------------------------------------------
module vec_pingpong_buf
    import dense_ser_pkg::*;
#(
    parameter int unsigned IN_SIZE  = DEF_IN_SIZE,
    parameter int unsigned OUT_SIZE = DEF_OUT_SIZE,
    parameter int unsigned BW       = DEF_BW,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [IN_SIZE*BW-1:0]    wr_data,
    input  logic                     rd_free,
    input  logic                     rd_slot_sel,
    input  logic [CNT_W-1:0]         rd_chunk_sel,
    output logic [OUT_SIZE*BW-1:0]   rd_data,
    output logic                     rd_slot,
    output logic [1:0]               occ
);

    localparam int unsigned NCHUNK  = nchunk(IN_SIZE, OUT_SIZE);
    localparam int unsigned CHUNK_W = OUT_SIZE * BW;

    typedef logic [NCHUNK-1:0][CHUNK_W-1:0] slot_t;

    slot_t      slot_mem_r [2];
    slot_t      wr_view_s;
    logic       wr_slot_r;
    logic       rd_slot_r;
    logic [1:0] occ_r;

    assign wr_view_s = wr_data;

    // Slot pointers and occupancy; a write and a free in one cycle cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_slot_r <= 1'b0;
            rd_slot_r <= 1'b0;
            occ_r     <= 2'd0;
        end else begin
            wr_slot_r <= wr_slot_r ^ wr_en;
            rd_slot_r <= rd_slot_r ^ rd_free;
            occ_r     <= occ_r + {1'b0, wr_en} - {1'b0, rd_free};
        end
    end

    // Vector storage; contents need no reset since occupancy gates their use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            slot_mem_r[wr_slot_r] <= wr_view_s;
        end
    end

    // Chunk read port with same-cycle forwarding of the vector being written.
    always_comb begin
        rd_data = {CHUNK_W{1'b0}};
        if (wr_en && (rd_slot_sel == wr_slot_r)) begin
            rd_data = wr_view_s[rd_chunk_sel];
        end else begin
            rd_data = slot_mem_r[rd_slot_sel][rd_chunk_sel];
        end
    end

    assign rd_slot = rd_slot_r;
    assign occ     = occ_r;

endmodule

// File: rtl/dense_out_serializer.sv
// ----------------------------------------------------------------------------
// dense_out_serializer
//   Captures a full dense-layer result vector on a single vld_in pulse and
//   streams it out OUT_SIZE words per cycle, chunk 0 first. Two vector slots
//   let a new vector be captured while the previous one streams; when both
//   slots are busy the incoming vector is dropped and ovf latches high.
//   Back-to-back buffered vectors stream without a bubble. First chunk appears
//   the cycle after capture.
// Configuration
//   DENSE_SER_RELU_EN : when defined, negative words are stored as 0 at
//                       capture (no extra latency); otherwise bit-exact.
// Ports
//   clk       clock, rising edge
//   rst       synchronous reset, active high
//   vld_in    one-cycle pulse: data_in holds a complete vector
//   data_in   packed [IN_SIZE-1:0][BW-1:0] vector
//   vld_out   data_out carries a valid chunk this cycle
//   data_out  packed [OUT_SIZE-1:0][BW-1:0] chunk (holds when vld_out=0)
//   last_out  high with the final chunk of each vector
//   ovf       sticky overflow, cleared only by rst
// ----------------------------------------------------------------------------
module dense_out_serializer
    import dense_ser_pkg::*;
#(
    parameter int unsigned IN_SIZE  = DEF_IN_SIZE,
    parameter int unsigned OUT_SIZE = DEF_OUT_SIZE,
    parameter int unsigned BW       = DEF_BW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   vld_in,
    input  logic [IN_SIZE*BW-1:0]  data_in,
    output logic                   vld_out,
    output logic [OUT_SIZE*BW-1:0] data_out,
    output logic                   last_out,
    output logic                   ovf
);

    localparam int unsigned NCHUNK  = nchunk(IN_SIZE, OUT_SIZE);
    localparam int unsigned CNT_W   = cnt_width(NCHUNK);
    localparam int unsigned CHUNK_W = OUT_SIZE * BW;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NCHUNK - 32'd1);

    ser_state_e             state_r;
    ser_state_e             state_next_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_next_s;

    logic [IN_SIZE*BW-1:0]  stored_s;
    logic                   capture_s;
    logic                   drop_s;
    logic                   last_issue_s;
    logic [1:0]             occ_s;
    logic [1:0]             occ_after_s;
    logic                   rd_slot_s;
    logic                   rd_slot_next_s;
    logic [CHUNK_W-1:0]     rd_chunk_s;

    logic                   vld_out_r;
    logic [CHUNK_W-1:0]     data_out_r;
    logic                   last_out_r;
    logic                   ovf_r;

`ifdef DENSE_SER_RELU_EN
    // Rectify each word on the way into the buffer.
    always_comb begin
        stored_s = {(IN_SIZE*BW){1'b0}};
        for (int i = 0; i < int'(IN_SIZE); i++) begin
            stored_s[i*BW +: BW] = BW'(relu_word(MAX_BW'(data_in[i*BW +: BW]), BW));
        end
    end
`else
    assign stored_s = data_in;
`endif

    vec_pingpong_buf #(
        .IN_SIZE  (IN_SIZE),
        .OUT_SIZE (OUT_SIZE),
        .BW       (BW),
        .CNT_W    (CNT_W)
    ) u_buf (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (capture_s),
        .wr_data      (stored_s),
        .rd_free      (last_issue_s),
        .rd_slot_sel  (rd_slot_next_s),
        .rd_chunk_sel (cnt_next_s),
        .rd_data      (rd_chunk_s),
        .rd_slot      (rd_slot_s),
        .occ          (occ_s)
    );

    // Capture/drop decision and post-update occupancy. A full buffer still
    // accepts when its read slot is released in the same cycle.
    always_comb begin
        last_issue_s = 1'b0;
        capture_s    = 1'b0;
        if ((state_r == STREAM) && (cnt_r == LAST_IDX)) begin
            last_issue_s = 1'b1;
        end else begin
            last_issue_s = 1'b0;
        end
        if (vld_in) begin
            if (occ_s < 2'd2) begin
                capture_s = 1'b1;
            end else if (last_issue_s) begin
                capture_s = 1'b1;
            end else begin
                capture_s = 1'b0;
            end
        end else begin
            capture_s = 1'b0;
        end
        drop_s         = vld_in & ~capture_s;
        occ_after_s    = occ_s + {1'b0, capture_s} - {1'b0, last_issue_s};
        rd_slot_next_s = rd_slot_s ^ last_issue_s;
    end

    // Next state and next chunk index. A vector captured in the final-chunk
    // cycle counts as buffered, so it follows with no idle cycle.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            IDLE: begin
                cnt_next_s = {CNT_W{1'b0}};
                if (capture_s || (occ_s != 2'd0)) begin
                    state_next_s = STREAM;
                end else begin
                    state_next_s = IDLE;
                end
            end
            STREAM: begin
                if (last_issue_s) begin
                    cnt_next_s = {CNT_W{1'b0}};
                    if (occ_after_s != 2'd0) begin
                        state_next_s = STREAM;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    cnt_next_s   = cnt_r + 1'b1;
                    state_next_s = STREAM;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // FSM state and chunk counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Output registers are loaded with the chunk of the upcoming STREAM cycle,
    // so vld_out/last_out always mirror state_r/cnt_r.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_out_r  <= 1'b0;
            data_out_r <= {CHUNK_W{1'b0}};
            last_out_r <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            vld_out_r  <= (state_next_s == STREAM);
            last_out_r <= (state_next_s == STREAM) && (cnt_next_s == LAST_IDX);
            if (state_next_s == STREAM) begin
                data_out_r <= rd_chunk_s;
            end else begin
                data_out_r <= data_out_r;
            end
            ovf_r <= ovf_r | drop_s;
        end
    end

    assign vld_out  = vld_out_r;
    assign data_out = data_out_r;
    assign last_out = last_out_r;
    assign ovf      = ovf_r;

endmodule

// File: tb/tb_dense_out_serializer.sv
// ----------------------------------------------------------------------------
// tb_dense_out_serializer
//   Scoreboard bench for dense_out_serializer (IN_SIZE=8, OUT_SIZE=2, BW=16).
//   Stimulus pushes the expected chunks (data, last flag, cycle) into a queue;
//   a negedge monitor pops and compares every chunk the DUT presents and
//   flags chunks that are late, missing or unexpected.
// ----------------------------------------------------------------------------
module tb_dense_out_serializer;

    localparam int IN_SIZE  = 8;
    localparam int OUT_SIZE = 2;
    localparam int BW       = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         vld_in;
    logic [127:0] data_in;
    logic         vld_out;
    logic [31:0]  data_out;
    logic         last_out;
    logic         ovf;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dense_out_serializer #(
        .IN_SIZE  (IN_SIZE),
        .OUT_SIZE (OUT_SIZE),
        .BW       (BW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .vld_in   (vld_in),
        .data_in  (data_in),
        .vld_out  (vld_out),
        .data_out (data_out),
        .last_out (last_out),
        .ovf      (ovf)
    );

    function automatic logic [127:0] vec8(input logic [15:0] w0, input logic [15:0] w1,
                                          input logic [15:0] w2, input logic [15:0] w3,
                                          input logic [15:0] w4, input logic [15:0] w5,
                                          input logic [15:0] w6, input logic [15:0] w7);
        return {w7, w6, w5, w4, w3, w2, w1, w0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Chunk k of a vector is words 2k (low half) and 2k+1 (high half).
    task automatic push_vec(input logic [127:0] v, input int start, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.data = v[k*32 +: 32];
            e.last = (k == 3);
            e.cyc  = start + k;
            sb_q.push_back(e);
        end
    endtask

    task automatic send(input logic [127:0] v);
        data_in = v;
        vld_in  = 1'b1;
        @(negedge clk);
        vld_in  = 1'b0;
        data_in = '0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check({tag, "_rst_vld"},  32'(vld_out),  32'd0);
        check({tag, "_rst_data"}, data_out,      32'd0);
        check({tag, "_rst_last"}, 32'(last_out), 32'd0);
        check({tag, "_rst_ovf"},  32'(ovf),      32'd0);
        check({tag, "_sb_drained"}, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        rst = 1'b0;
    endtask

    // Monitor: every presented chunk must match the head of the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (vld_out === 1'b1) begin
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_chunk: got data %h last %b at cycle %0d, expected no output",
                             data_out, last_out, cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (data_out !== mon_e.data || last_out !== mon_e.last || cyc != mon_e.cyc) begin
                        n_fail++;
                        $display("FAIL chunk: got data %h last %b cycle %0d, expected data %h last %b cycle %0d",
                                 data_out, last_out, cyc, mon_e.data, mon_e.last, mon_e.cyc);
                    end
                end
            end else begin
                n_tests++;
                if (vld_out !== 1'b0 || last_out !== 1'b0) begin
                    n_fail++;
                    $display("FAIL idle_outputs: got vld %b last %b at cycle %0d, expected 0 0",
                             vld_out, last_out, cyc);
                end
                if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                    mon_e = sb_q.pop_front();
                    n_fail++;
                    $display("FAIL missing_chunk: got no output at cycle %0d, expected data %h at cycle %0d",
                             cyc, mon_e.data, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        logic [127:0] va, vb, vc, vd, vexp;
        int t;

        rst     = 1'b1;
        vld_in  = 1'b0;
        data_in = '0;
        repeat (3) @(negedge clk);
        check("reset_vld",  32'(vld_out),  32'd0);
        check("reset_data", data_out,      32'd0);
        check("reset_last", 32'(last_out), 32'd0);
        check("reset_ovf",  32'(ovf),      32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // 1: single vector 1..8 -> {1,2},{3,4},{5,6},{7,8} at t+1..t+4
        t  = cyc;
        va = vec8(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8);
        push_vec(va, t + 1, 4);
        send(va);
        repeat (6) @(negedge clk);
        check("t1_ovf", 32'(ovf), 32'd0);

        // 2: A at t, B at t+2 -> A t+1..t+4, B t+5..t+8, no gap
        do_reset("t2");
        t  = cyc;
        va = vec8(16'h0A00, 16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04, 16'h0A05, 16'h0A06, 16'h0A07);
        vb = vec8(16'hB000, 16'hB001, 16'hB002, 16'hB003, 16'hB004, 16'hB005, 16'hB006, 16'hB007);
        push_vec(va, t + 1, 4);
        send(va);
        @(negedge clk);
        push_vec(vb, t + 5, 4);
        send(vb);
        repeat (8) @(negedge clk);
        check("t2_ovf", 32'(ovf), 32'd0);

        // 3a: third vector at t+3 is dropped, ovf from t+4 onward
        do_reset("t3a");
        t  = cyc;
        vc = vec8(16'hC000, 16'hC001, 16'hC002, 16'hC003, 16'hC004, 16'hC005, 16'hC006, 16'hC007);
        push_vec(va, t + 1, 4);
        send(va);
        @(negedge clk);
        push_vec(vb, t + 5, 4);
        send(vb);
        check("t3a_ovf_before_drop", 32'(ovf), 32'd0);
        send(vc);
        check("t3a_ovf_at_t4", 32'(ovf), 32'd1);
        repeat (10) @(negedge clk);
        check("t3a_ovf_sticky", 32'(ovf), 32'd1);

        // 3b: third vector at t+4 (A's last chunk) accepted, streams t+9..t+12
        do_reset("t3b");
        t = cyc;
        push_vec(va, t + 1, 4);
        send(va);
        @(negedge clk);
        push_vec(vb, t + 5, 4);
        send(vb);
        @(negedge clk);
        push_vec(vc, t + 9, 4);
        send(vc);
        repeat (10) @(negedge clk);
        check("t3b_ovf", 32'(ovf), 32'd0);

        // 4: rectification (or bit-exact pass-through without it)
        do_reset("t4");
        t  = cyc;
        vd = vec8(16'hFFFF, 16'h0005, 16'h8000, 16'h7FFF, 16'hFFFD, 16'h0002, 16'h0000, 16'hFFF9);
`ifdef DENSE_SER_RELU_EN
        vexp = vec8(16'h0000, 16'h0005, 16'h0000, 16'h7FFF, 16'h0000, 16'h0002, 16'h0000, 16'h0000);
`else
        vexp = vec8(16'hFFFF, 16'h0005, 16'h8000, 16'h7FFF, 16'hFFFD, 16'h0002, 16'h0000, 16'hFFF9);
`endif
        push_vec(vexp, t + 1, 4);
        send(vd);
        repeat (6) @(negedge clk);

        // 5: rst at t+2 with B buffered: A cut after two chunks, B never appears
        do_reset("t5");
        t = cyc;
        push_vec(va, t + 1, 2);
        send(va);
        send(vb);
        rst = 1'b1;
        @(negedge clk);
        check("t5_vld_after_rst",  32'(vld_out),  32'd0);
        check("t5_last_after_rst", 32'(last_out), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        t = cyc;
        push_vec(vc, t + 1, 4);
        send(vc);
        repeat (8) @(negedge clk);
        check("t5_ovf", 32'(ovf), 32'd0);

        @(negedge clk);
        check("final_sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
